// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared types and sizing helpers for the two-way packet arbiter
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Counter must be able to hold MAX_BEATS itself
  function automatic int beat_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mux2_rr_pick.sv
// rtl/mux2_rr_pick.sv - combinational next-grant picker; rr_ptr breaks ties
module mux2_rr_pick (
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic rr_ptr,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0_valid | req1_valid;
  assign grant_id    = (req0_valid & req1_valid) ? rr_ptr : req1_valid;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin packet arbiter owning the shared 2:1 mux channel
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy,
  output logic              trunc_err
);

  localparam int CNT_W = beat_cnt_w(MAX_BEATS);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             grant_valid;
  logic             grant_id;
  logic             xfer;
  logic             at_limit;
  logic             rel_beat;
  logic             trunc_nxt;

  mux2_rr_pick u_pick (
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign xfer      = out_valid && out_ready;
  assign at_limit  = (beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BEATS);
  assign rel_beat  = xfer && (out_last || at_limit);
  // A last beat landing exactly on the limit is a clean release
  assign trunc_nxt = xfer && !out_last && at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (grant_valid) state_nxt = grant_id ? GRANT1 : GRANT0;
      GRANT0, GRANT1: if (rel_beat)    state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Idle drives zeros so nothing leaks from either requester between grants
  always_comb begin
    sel        = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      GRANT0: begin
        busy       = 1'b1;
        out_valid  = req0_valid;
        out_data   = req0_data;
        out_last   = req0_last;
        req0_ready = out_ready;
      end
      GRANT1: begin
        sel        = 1'b1;
        busy       = 1'b1;
        out_valid  = req1_valid;
        out_data   = req1_data;
        out_last   = req1_last;
        req1_ready = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      beat_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= trunc_nxt;
      if (rel_beat) begin
        beat_cnt <= '0;
        rr_ptr   <= ~sel;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed self-checking bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, busy, trunc_err;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_d;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BEATS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy),
    .trunc_err  (trunc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    out_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    chk("rst_trunc", trunc_err, 0);
    chk("rst_ready0", req0_ready, 0);
    nxt();
    rst = 1'b0;

    // Contention: alternating 2-beat packets, grant order 0,1,0,1 with bubbles
    req0_valid = 1; req0_data = 8'h10; req0_last = 0;
    req1_valid = 1; req1_data = 8'h20; req1_last = 0;
    out_ready  = 1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("cont_bubble_busy", busy, 0);
      chk("cont_bubble_valid", out_valid, 0);
      nxt();
      mid();
      exp_d = (k[0] ? 8'h20 : 8'h10) + 8'(2 * (k / 2));
      chk("cont_sel", sel, k[0]);
      chk("cont_beat1", out_data, exp_d);
      chk("cont_other_ready", k[0] ? req0_ready : req1_ready, 0);
      nxt();
      if (k[0]) begin req1_data = exp_d + 8'd1; req1_last = 1; end
      else      begin req0_data = exp_d + 8'd1; req0_last = 1; end
      mid();
      chk("cont_beat2", out_data, exp_d + 8'd1);
      chk("cont_last", out_last, 1);
      nxt();
      if (k[0]) begin req1_data = exp_d + 8'd2; req1_last = 0; req1_valid = (k < 2); end
      else      begin req0_data = exp_d + 8'd2; req0_last = 0; req0_valid = (k < 2); end
    end

    // Single requester, 3 beats
    req0_valid = 1; req0_data = 8'hA1; req0_last = 0;
    mid();
    chk("single_c0_valid", out_valid, 0);
    nxt();
    mid();
    chk("single_c1_valid", out_valid, 1);
    chk("single_c1_data", out_data, 8'hA1);
    chk("single_c1_busy", busy, 1);
    chk("single_c1_r1rdy", req1_ready, 0);
    nxt();
    req0_data = 8'hA2;
    mid();
    chk("single_c2_data", out_data, 8'hA2);
    chk("single_c2_r1rdy", req1_ready, 0);
    nxt();
    req0_data = 8'hA3; req0_last = 1;
    mid();
    chk("single_c3_data", out_data, 8'hA3);
    chk("single_c3_last", out_last, 1);
    nxt();
    req0_valid = 0; req0_last = 0;
    mid();
    chk("single_c4_busy", busy, 0);
    chk("single_c4_valid", out_valid, 0);

    // Reset mid-grant; rr_ptr is 1 beforehand so the tie-break shows it was cleared
    nxt();
    req0_valid = 1; req0_data = 8'hB1;
    nxt();
    mid();
    chk("rstg_busy", busy, 1);
    nxt();
    req0_data = 8'hB2;
    mid();
    chk("rstg_beat2", out_data, 8'hB2);
    #1 rst = 1'b1;
    #1;
    chk("rstg_async_valid", out_valid, 0);
    chk("rstg_async_busy", busy, 0);
    chk("rstg_async_sel", sel, 0);
    chk("rstg_async_ready", req0_ready, 0);
    chk("rstg_async_data", out_data, 0);
    nxt();
    rst = 1'b0;
    req0_data = 8'hB3; req0_last = 1;
    req1_valid = 1; req1_data = 8'hC1; req1_last = 1;
    mid();
    chk("rstg_idle", busy, 0);
    nxt();
    mid();
    chk("rstg_rrptr_sel", sel, 0);
    chk("rstg_rrptr_data", out_data, 8'hB3);
    nxt();
    req0_valid = 0; req0_last = 0;
    mid();
    chk("rstg_bubble", busy, 0);
    nxt();
    mid();
    chk("rstg_g1_sel", sel, 1);
    chk("rstg_g1_data", out_data, 8'hC1);
    nxt();
    req1_valid = 0; req1_last = 0;
    mid();
    chk("rstg_end_busy", busy, 0);

    // Backpressure on a req1 grant; packet also ends with last at the limit
    req1_valid = 1; req1_data = 8'hD1;
    nxt();
    mid();
    chk("bp_sel", sel, 1);
    chk("bp_d1", out_data, 8'hD1);
    nxt();
    req1_data = 8'hD2; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_stall_ready", req1_ready, 0);
      chk("bp_stall_data", out_data, 8'hD2);
      chk("bp_stall_busy", busy, 1);
      nxt();
    end
    out_ready = 1;
    mid();
    chk("bp_resume_ready", req1_ready, 1);
    chk("bp_resume_data", out_data, 8'hD2);
    nxt();
    req1_data = 8'hD3;
    mid();
    chk("bp_d3", out_data, 8'hD3);
    chk("bp_d3_busy", busy, 1);
    chk("bp_d3_trunc", trunc_err, 0);
    nxt();
    req1_data = 8'hD4; req1_last = 1;
    mid();
    chk("bp_d4", out_data, 8'hD4);
    chk("bp_d4_busy", busy, 1);
    nxt();
    req1_valid = 0; req1_last = 0;
    mid();
    chk("lastlim_busy", busy, 0);
    chk("lastlim_trunc", trunc_err, 0);

    // Truncation: req0 streams without last, req1 waits
    req0_valid = 1; req0_data = 8'hE0; req0_last = 0;
    req1_valid = 1; req1_data = 8'hF0; req1_last = 1;
    nxt();
    for (int b = 0; b < 4; b++) begin
      mid();
      chk("trunc_beat", out_data, 8'hE0 + 8'(b));
      chk("trunc_busy", busy, 1);
      chk("trunc_pre", trunc_err, 0);
      nxt();
      req0_data = 8'hE0 + 8'(b + 1);
    end
    mid();
    chk("trunc_rel_busy", busy, 0);
    chk("trunc_pulse", trunc_err, 1);
    nxt();
    mid();
    chk("trunc_pulse_end", trunc_err, 0);
    chk("trunc_next_sel", sel, 1);
    chk("trunc_next_data", out_data, 8'hF0);
    nxt();
    req0_valid = 0; req1_valid = 0; req1_last = 0;
    mid();
    chk("trunc_final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
